// File: rtl/div_unit.sv
// Iterative radix-2 restoring divide/remainder unit (DIV, DIVU, REM, REMU) for the execute stage.
// Optional DIV_FASTPATH_EN: zero-divisor and signed-overflow cases finish at the accept edge.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iFlush,
    input  logic [4:0]       iControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);

    // Operation codes shared with the ALU decoder.
    localparam logic [4:0] OPDIV  = 5'd10;
    localparam logic [4:0] OPDIVU = 5'd11;
    localparam logic [4:0] OPREM  = 5'd12;
    localparam logic [4:0] OPREMU = 5'd13;

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [WIDTH-1:0] result_n;
    logic             op_rem, op_rem_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic             busy_n, done_n;

    logic             is_div, is_signed, is_rem_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shift;
    logic             ge;
`ifdef DIV_FASTPATH_EN
    logic             fast;
    logic [WIDTH-1:0] fast_res;
`endif

    // Operand decode and one restoring step of the datapath.
    always_comb begin
        is_div    = (iControl == OPDIV) || (iControl == OPDIVU) ||
                    (iControl == OPREM) || (iControl == OPREMU);
        is_signed = (iControl == OPDIV) || (iControl == OPREM);
        is_rem_op = (iControl == OPREM) || (iControl == OPREMU);
        a_neg     = is_signed & iA[WIDTH-1];
        b_neg     = is_signed & iB[WIDTH-1];
        a_abs     = a_neg ? -iA : iA;
        b_abs     = b_neg ? -iB : iB;
        shift     = {rem, quo[WIDTH-1]};
        ge        = (shift >= {1'b0, dvs});
`ifdef DIV_FASTPATH_EN
        fast      = (iB == '0) ||
                    (is_signed && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (iB == '1));
        if (iB == '0)
            fast_res = is_rem_op ? iA : '1;
        else
            fast_res = is_rem_op ? '0 : iA;
`endif
    end

    // Next-state and next-register logic; flush overrides everything but reset.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        op_rem_n = op_rem;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = oResult;

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (iStart && is_div) begin
                    op_rem_n = is_rem_op;
                    neg_q_n  = a_neg ^ b_neg;
                    neg_r_n  = a_neg;
                    quo_n    = a_abs;
                    rem_n    = '0;
                    dvs_n    = b_abs;
                    cnt_n    = CW'(WIDTH - 1);
                    state_n  = CALC;
`ifdef DIV_FASTPATH_EN
                    if (fast) begin
                        state_n  = DONE;
                        result_n = fast_res;
                    end
`endif
                end
            end
            CALC: begin
                quo_n = {quo[WIDTH-2:0], ge};
                rem_n = ge ? WIDTH'(shift - {1'b0, dvs}) : shift[WIDTH-1:0];
                cnt_n = cnt - CW'(1);
                if (cnt == '0)
                    state_n = ADJ;
            end
            ADJ: begin
                // A zero divisor keeps the all-ones quotient unsigned.
                if (op_rem)
                    result_n = neg_r ? -rem : rem;
                else
                    result_n = (neg_q && (dvs != '0)) ? -quo : quo;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase

        if (iFlush) begin
            state_n  = IDLE;
            result_n = oResult;
        end

        busy_n = (state_n == CALC) || (state_n == ADJ);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oResult <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rem     <= rem_n;
            quo     <= quo_n;
            dvs     <= dvs_n;
            op_rem  <= op_rem_n;
            neg_q   <= neg_q_n;
            neg_r   <= neg_r_n;
            oBusy   <= busy_n;
            oDone   <= done_n;
            oResult <= result_n;
        end
    end

endmodule
